// File: rtl/zap_fetch_pkg.sv
// Shared types and constants for the fetch supplier: FSM encoding, prefetch entry layout.
// Optional build macro used by the top: ZAP_FETCH_SUPPLIER_ALIGN_CHK_EN.
package zap_fetch_pkg;

    localparam int unsigned ENTRY_W  = 65;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam logic [DATA_W-1:0] ABORT_PAYLOAD = 32'd0;
    localparam logic [ADDR_W-1:0] FETCH_STRIDE  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] instruction;
        logic              abort;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Force an address onto a 32-bit word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/zap_fetch_fifo.sv
// Prefetch FIFO of fetch entries; head is presented directly, flush may coincide with a push.
module zap_fetch_fifo
    import zap_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CNT_W-1:0] count;
    logic           do_pop;
    logic           do_push;

    assign o_empty = (count == '0);
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_count = count;
    assign o_head  = mem[rd_ptr];

    // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = i_pop & ~o_empty;
    assign do_push = i_push & (~o_full | do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            // Flush empties the FIFO; a coincident push becomes the only entry.
            rd_ptr <= '0;
            wr_ptr <= i_push ? AW'(1) : '0;
            count  <= i_push ? CNT_W'(1) : '0;
            if (i_push) begin
                mem[0] <= i_push_data;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/zap_fetch_supplier.sv
// Instruction prefetch unit: Wishbone-style single-outstanding fetcher feeding a small FIFO.
// Build macro ZAP_FETCH_SUPPLIER_ALIGN_CHK_EN turns misaligned redirects into abort entries.
module zap_fetch_supplier
    import zap_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pc_load,
    input  logic [31:0] i_pc,
    input  logic        i_stall,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    output logic [31:0] o_instruction,
    output logic        o_valid,
    output logic        o_instr_abort,
    output logic [31:0] o_pc
);

    fetch_state_t   state;
    logic [31:0]    fetch_ptr;
    logic           drain_to_halt;
    logic           misalign_c;
    logic           bus_done_c;
    logic           push_c;
    logic           pop_c;
    fetch_entry_t   push_data_c;
    fetch_entry_t   head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [$clog2(DEPTH):0] count_unused;

`ifdef ZAP_FETCH_SUPPLIER_ALIGN_CHK_EN
    assign misalign_c = i_pc_load & (i_pc[1:0] != 2'b00);
`else
    assign misalign_c = 1'b0;
`endif

    assign bus_done_c = o_wb_cyc & (i_wb_ack | i_wb_err);
    assign pop_c      = ~fifo_empty & ~i_stall;

    // Entry to push: misaligned-redirect abort, bus fault abort, or fetched word.
    always_comb begin
        push_c                  = 1'b0;
        push_data_c.instruction = ABORT_PAYLOAD;
        push_data_c.abort       = 1'b1;
        push_data_c.pc          = i_pc;
        if (i_pc_load) begin
            push_c = misalign_c;
        end else if ((state == BUSY) && bus_done_c) begin
            push_c         = 1'b1;
            push_data_c.pc = o_wb_adr;
            if (!i_wb_err) begin
                push_data_c.instruction = i_wb_dat;
                push_data_c.abort       = 1'b0;
            end
        end
    end

    zap_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_push      (push_c),
        .i_push_data (push_data_c),
        .i_pop       (pop_c),
        .i_flush     (i_pc_load),
        .o_head      (head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (count_unused)
    );

    assign o_valid       = ~fifo_empty;
    assign o_instruction = head.instruction;
    assign o_instr_abort = head.abort;
    assign o_pc          = head.pc;

    // Fetch FSM; bus qualifiers and address are registered.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state         <= IDLE;
            fetch_ptr     <= '0;
            drain_to_halt <= 1'b0;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_adr      <= '0;
        end else if (i_pc_load) begin
            fetch_ptr <= word_align(i_pc);
            if (((state == BUSY) || (state == DRAIN)) && !bus_done_c) begin
                // Request still in flight: keep it on the bus and throw its response away.
                state         <= DRAIN;
                drain_to_halt <= misalign_c;
            end else begin
                state         <= misalign_c ? HALT : IDLE;
                drain_to_halt <= 1'b0;
                o_wb_cyc      <= 1'b0;
                o_wb_stb      <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        state    <= BUSY;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= 1'b1;
                        o_wb_adr <= fetch_ptr;
                    end
                end
                BUSY: begin
                    if (bus_done_c) begin
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (i_wb_err) begin
                            state <= HALT;
                        end else begin
                            state     <= IDLE;
                            fetch_ptr <= fetch_ptr + FETCH_STRIDE;
                        end
                    end
                end
                DRAIN: begin
                    if (bus_done_c) begin
                        o_wb_cyc      <= 1'b0;
                        o_wb_stb      <= 1'b0;
                        drain_to_halt <= 1'b0;
                        state         <= drain_to_halt ? HALT : IDLE;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
